// File: rtl/i2c_arbiter_if.sv
// Bus bundles for the I2C arbiter: requester side and I2C-master side.
// The arbiter takes the slave end of the requester bus and the master end of the I2C-master bus.
interface i2c_req_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [7*NREQ-1:0] req_addr;
    logic [NREQ-1:0]   req_op;
    logic [8*NREQ-1:0] req_din;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [7:0]        rsp_data;
    logic              rsp_err;
    logic              rsp_to;

    modport master (
        output req, req_addr, req_op, req_din,
        input  gnt, rsp_valid, rsp_data, rsp_err, rsp_to
    );
    modport slave (
        input  req, req_addr, req_op, req_din,
        output gnt, rsp_valid, rsp_data, rsp_err, rsp_to
    );
endinterface

interface i2c_mst_if;
    logic       m_newd;
    logic [6:0] m_addr;
    logic       m_op;
    logic [7:0] m_din;
    logic       m_busy;
    logic       m_done;
    logic       m_ack_err;
    logic [7:0] m_dout;

    modport master (
        output m_newd, m_addr, m_op, m_din,
        input  m_busy, m_done, m_ack_err, m_dout
    );
    modport slave (
        input  m_newd, m_addr, m_op, m_din,
        output m_busy, m_done, m_ack_err, m_dout
    );
endinterface

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master among NREQ requesters,
// with a launch-to-done watchdog that drains the master before reporting a timeout.
module i2c_arbiter #(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic      clk,
    input  logic      rst,
    i2c_req_if.slave  rq,
    i2c_mst_if.master mi
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_DONE, RESP, DRAIN} state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [7:0]      rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;
    logic            rsp_to_q, rsp_to_d;
    logic            m_newd_q, m_newd_d;
    logic [6:0]      m_addr_q, m_addr_d;
    logic            m_op_q, m_op_d;
    logic [7:0]      m_din_q, m_din_d;
    logic [CW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   win_q, win_d;
    logic [IW-1:0]   pick;

    // First requester above last_winner, else the lowest one at or below it.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] last);
        logic [IW-1:0] sel   = '0;
        logic          found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && r[i] && (IW'(i) > last)) begin
                sel   = IW'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && r[i]) begin
                sel   = IW'(i);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        gnt_d       = gnt_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rsp_to_d    = rsp_to_q;
        m_newd_d    = m_newd_q;
        m_addr_d    = m_addr_q;
        m_op_d      = m_op_q;
        m_din_d     = m_din_q;
        tmo_cnt_d   = tmo_cnt_q;
        last_d      = last_q;
        win_d       = win_q;
        pick        = rr_pick(rq.req, last_q);

        unique case (state_q)
            IDLE: begin
                if ((|rq.req) && !mi.m_busy) begin
                    win_d     = pick;
                    gnt_d     = '0;
                    m_newd_d  = 1'b1;
                    tmo_cnt_d = '0;
                    state_d   = LAUNCH;
                    for (int i = 0; i < NREQ; i++) begin
                        if (IW'(i) == pick) begin
                            gnt_d[i] = 1'b1;
                            m_addr_d = rq.req_addr[7*i +: 7];
                            m_op_d   = rq.req_op[i];
                            m_din_d  = rq.req_din[8*i +: 8];
                        end
                    end
                end
            end
            LAUNCH: begin
                tmo_cnt_d = tmo_cnt_q + CW'(1);
                if (tmo_cnt_q == TMO_LAST) begin
                    m_newd_d = 1'b0;
                    state_d  = DRAIN;
                end else if (mi.m_busy) begin
                    m_newd_d = 1'b0;
                    state_d  = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                tmo_cnt_d = tmo_cnt_q + CW'(1);
                // A completion in the expiry cycle still counts as a normal finish.
                if (mi.m_done) begin
                    rsp_data_d  = mi.m_dout;
                    rsp_err_d   = mi.m_ack_err;
                    rsp_to_d    = 1'b0;
                    rsp_valid_d = gnt_q;
                    state_d     = RESP;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!mi.m_busy) begin
                    rsp_data_d  = 8'h00;
                    rsp_err_d   = 1'b1;
                    rsp_to_d    = 1'b1;
                    rsp_valid_d = gnt_q;
                    state_d     = RESP;
                end
            end
            RESP: begin
                gnt_d   = '0;
                last_d  = win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
            m_newd_q    <= 1'b0;
            m_addr_q    <= '0;
            m_op_q      <= 1'b0;
            m_din_q     <= '0;
            tmo_cnt_q   <= '0;
            last_q      <= IW'(NREQ - 1);
            win_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
            m_newd_q    <= m_newd_d;
            m_addr_q    <= m_addr_d;
            m_op_q      <= m_op_d;
            m_din_q     <= m_din_d;
            tmo_cnt_q   <= tmo_cnt_d;
            last_q      <= last_d;
            win_q       <= win_d;
        end
    end

    assign rq.gnt       = gnt_q;
    assign rq.rsp_valid = rsp_valid_q;
    assign rq.rsp_data  = rsp_data_q;
    assign rq.rsp_err   = rsp_err_q;
    assign rq.rsp_to    = rsp_to_q;
    assign mi.m_newd    = m_newd_q;
    assign mi.m_addr    = m_addr_q;
    assign mi.m_op      = m_op_q;
    assign mi.m_din     = m_din_q;
endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter: NREQ, default 4, number of requester ports (2..8).
REQ-002 Parameter: TIMEOUT_CYC, default 20000, clk cycles allowed from launch to m_done before abort.
REQ-003 Port: clk  input  1  system clock; all logic on posedge clk.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: req  input  NREQ  per-requester transaction request; held high until that requester's rsp_valid bit.
REQ-006 Port: req_addr  input  7*NREQ  7-bit slave address per requester; slice i = bits [7i+6:7i].
REQ-007 Port: req_op  input  NREQ  per-requester op; 0 = write, 1 = read.
REQ-008 Port: req_din  input  8*NREQ  write byte per requester; slice i = bits [8i+7:8i].
REQ-009 Port: gnt  output  NREQ  one-hot grant, held for the whole transaction.
REQ-010 Port: rsp_valid  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-011 Port: rsp_data  output  8  read byte; valid with rsp_valid.
REQ-012 Port: rsp_err  output  1  ack error or timeout; valid with rsp_valid.
REQ-013 Port: rsp_to  output  1  timeout flag; valid with rsp_valid.
REQ-014 Port: m_newd  output  1  start strobe to the I2C master.
REQ-015 Port: m_addr / m_op / m_din  output  7 / 1 / 8  transaction fields to the master; stable while gnt is non-zero.
REQ-016 Port: m_busy / m_done / m_ack_err  input  1 each  master status; m_done is a one-cycle pulse.
REQ-017 Port: m_dout  input  8  master read data; valid when m_done pulses.

Function
REQ-018 The FSM SHALL have states IDLE, LAUNCH, WAIT_DONE, RESP, DRAIN.
REQ-019 IDLE: if any req bit is high and m_busy=0, select a winner by round-robin, capture its addr/op/din into m_addr/m_op/m_din, set gnt one-hot, go to LAUNCH; otherwise stay in IDLE.
REQ-020 Round-robin: search starts at index (last_winner+1) mod NREQ, ascending with wrap; last_winner resets to NREQ-1, so index 0 has first priority after reset.
REQ-021 LAUNCH: m_newd=1; when m_busy=1 is sampled, deassert m_newd next cycle and go to WAIT_DONE.
REQ-022 WAIT_DONE: on m_done=1, capture m_dout into rsp_data and m_ack_err into rsp_err, set rsp_to=0, go to RESP.
REQ-023 RESP: for exactly one cycle, rsp_valid[winner]=1 and gnt=winner; next cycle gnt=0, update last_winner, go to IDLE.
REQ-024 Latency: gnt and m_newd rise 1 cycle after req is sampled in IDLE; rsp_valid rises 1 cycle after m_done.
REQ-025 Timeout counter: cleared on entry to LAUNCH, increments each cycle in LAUNCH/WAIT_DONE; at TIMEOUT_CYC-1, go to DRAIN with m_newd=0.
REQ-026 DRAIN: wait for m_busy=0, then go to RESP with rsp_err=1, rsp_to=1, rsp_data=8'h00.
REQ-027 m_done arriving in the same cycle as the timeout expiry SHALL win: normal completion, rsp_to=0.
REQ-028 Requester inputs changing after the grant SHALL NOT affect the in-flight transaction; a req dropped mid-transaction SHALL NOT abort it, and its rsp_valid still pulses.
REQ-029 A requester whose req is still high in the IDLE cycle after its rsp_valid SHALL be treated as a new request, subject to round-robin.
REQ-030 rsp_data, rsp_err and rsp_to SHALL hold their values until the next RESP.

Reset
REQ-031 On rst=1, asynchronously: state=IDLE; gnt, rsp_valid, m_newd, rsp_err and rsp_to = 0; rsp_data, m_addr, m_op and m_din = 0; timeout counter = 0; last_winner = NREQ-1.
REQ-032 Reset mid-transaction SHALL produce no rsp_valid; after release, the arbiter waits in IDLE until m_busy=0 before granting.

Verification
REQ-033 Single write: req[1]=1, addr=7'h50, op=0, din=8'hA5; master model pulses m_done with m_ack_err=0 -> gnt=4'b0010, m_addr=7'h50, m_din=8'hA5, then rsp_valid=4'b0010, rsp_err=0.
REQ-034 Read: req[2], op=1; m_done with m_dout=8'h3C -> rsp_data=8'h3C, rsp_valid=4'b0100.
REQ-035 Contention: req=4'b1111 held continuously -> grant order 0,1,2,3,0, with exactly one gnt bit active at a time.
REQ-036 NACK: m_ack_err=1 at m_done -> rsp_err=1, rsp_to=0.
REQ-037 Timeout: TIMEOUT_CYC=50, master never pulses m_done, m_busy drops at cycle 80 -> rsp_valid after m_busy=0, with rsp_err=1, rsp_to=1, rsp_data=8'h00.
REQ-038 Reset in WAIT_DONE -> all outputs 0 immediately, no rsp_valid, and next grant goes to index 0.
